ieeedrv_track_loader: RTL and testbench
=======================================

IEEEDRV_TRACK_LOADER -- requirements
Module: ieeedrv_track_loader

Interface
REQ-001 SHALL have ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- drv_type  in  1  0=8250 geometry, 1=4040 geometry
- img_mounted  in  1  one-cycle pulse: image (re)mounted
- img_size  in  32  mounted image size in bytes; sampled on img_mounted
- img_readonly  in  1  image write-protected
- track  in  7  current head track index from step stage (0-based)
- save_track  in  1  toggle; each edge = dirty-track save request
- sd_lba  out  32  256-byte block address of the current transfer
- sd_rd  out  1  read request
- sd_wr  out  1  write request
- sd_ack  in  1  host transfer in progress
- sd_buff_addr  in  8  byte index within block
- sd_buff_wr  in  1  host byte write strobe
- buf_addr  out  13  track RAM address {sector[4:0], byte[7:0]}
- buf_we  out  1  track RAM write enable
- busy  out  1  transfer pending or active
- track_ok  out  1  track RAM holds valid data for the latched track

Function
REQ-002 Geometry: use 1-based physical track t = track+1; SPT = sectors per track; start = first block of track t.
REQ-003 4040 zones SHALL be:
- t 1-17: SPT 21, start (t-1)*21
- t 18-24: SPT 19, start 357+(t-18)*19
- t 25-30: SPT 18, start 490+(t-25)*18
- t 31-35: SPT 17, start 598+(t-31)*17
- t>35: invalid
REQ-004 8250 zones SHALL be:
- t 1-39: SPT 29, start (t-1)*29
- t 40-53: SPT 27, start 1131+(t-40)*27
- t 54-64: SPT 25, start 1509+(t-54)*25
- t 65-77: SPT 23, start 1784+(t-65)*23
- only side 0 is handled.
REQ-005 A track is invalid if out of zone range or (start+SPT)*256 > latched img_size; an invalid track SHALL produce no transfer and set track_ok=0.
REQ-006 States SHALL be IDLE, SAVE_REQ, SAVE_WAIT, LOAD_REQ, LOAD_WAIT.
REQ-007 Pending flags:
- save_pend set on any save_track edge, unless img_readonly (then discarded)
- load_pend set when track != cur_track, or on img_mounted with img_size != 0.
REQ-008 IDLE priority SHALL be save_pend before load_pend; SAVE uses cur_track geometry, LOAD latches cur_track<=track first.
REQ-009 *_REQ: drive sd_lba = start+sector and assert sd_rd (LOAD) or sd_wr (SAVE); on sd_ack=1 deassert the request and go *_WAIT.
REQ-010 *_WAIT: on sd_ack=0, sector++; if sector==SPT, clear the pend flag and go IDLE (LOAD also sets track_ok=1); else return to *_REQ.
REQ-011 buf_addr = {sector, sd_buff_addr}; buf_we = sd_buff_wr & sd_ack & state==LOAD_WAIT.
REQ-012 Track change during LOAD: finish the current block, then restart LOAD at sector 0 with the new track (track_ok stays 0).
REQ-013 Track change during SAVE: complete all SAVE blocks of the old track, then LOAD.
REQ-014 img_mounted at any time: clear save_pend, track_ok<=0, set load_pend; an active block SHALL be completed (no request dropped mid-ack).
REQ-015 busy = state!=IDLE or save_pend or load_pend.

Reset
REQ-016 Reset SHALL force: state IDLE; sd_rd=0, sd_wr=0, sd_lba=0; sector=0; save_pend=0, load_pend=0; track_ok=0; cur_track=0; latched img_size=0; save_track edge detector reloaded from the input, so no spurious save follows.

Structure
REQ-017 Shared package ieeedrv_pkg SHALL hold the state enum and the zone boundary, SPT and start-offset constants for both drive types.
REQ-018 Geometry (REQ-003..005) SHALL be a combinational sub-module ieeedrv_track_geom: in drv_type, track, img_size; out spt[4:0], start[11:0], valid.

Verification
REQ-019 4040, 174848-byte image mounted, track=0 -> 21 reads, LBA 0..20, then track_ok=1, busy=0.
REQ-020 4040, track 17->18 -> loads 19 blocks, LBA 357..375.
REQ-021 8250, save_track toggle then track 38->39 -> 29 writes at LBA 1102..1130, then 27 reads at LBA 1131..1157.
REQ-022 Track changes 5->6 while block 3 of the load is acked -> block 3 completes, then reads restart at LBA 126 (4040).
REQ-023 img_readonly=1, save_track toggles -> no sd_wr; 4040, track=40 -> no sd_rd, track_ok=0.
REQ-024 Reset asserted in LOAD_WAIT -> next cycle sd_rd=0, busy=0, track_ok=0.

Source files
------------

// File: rtl/ieeedrv_pkg.sv
// Shared FSM encoding and per-drive zone tables for the IEEE drive track loader.
// Row 0 of each table is the 8250 geometry, row 1 the 4040 geometry.
package ieeedrv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE_REQ,
        S_SAVE_WAIT,
        S_LOAD_REQ,
        S_LOAD_WAIT
    } state_t;

    localparam int unsigned ZONES = 4;

    // Zone bounds are 1-based physical track numbers.
    localparam logic [7:0] ZONE_FIRST [2][4] = '{
        '{8'd1, 8'd40, 8'd54, 8'd65},
        '{8'd1, 8'd18, 8'd25, 8'd31}
    };
    localparam logic [7:0] ZONE_LAST [2][4] = '{
        '{8'd39, 8'd53, 8'd64, 8'd77},
        '{8'd17, 8'd24, 8'd30, 8'd35}
    };
    localparam logic [4:0] ZONE_SPT [2][4] = '{
        '{5'd29, 5'd27, 5'd25, 5'd23},
        '{5'd21, 5'd19, 5'd18, 5'd17}
    };
    localparam logic [11:0] ZONE_START [2][4] = '{
        '{12'd0, 12'd1131, 12'd1509, 12'd1784},
        '{12'd0, 12'd357,  12'd490,  12'd598}
    };

endpackage

// File: rtl/ieeedrv_track_geom.sv
// Combinational track geometry: sectors per track, first 256-byte block and
// whether the whole track fits inside the mounted image.
module ieeedrv_track_geom
    import ieeedrv_pkg::*;
(
    input  logic        drv_type,
    input  logic [6:0]  track,
    input  logic [31:0] img_size,
    output logic [4:0]  spt,
    output logic [11:0] start,
    output logic        valid
);

    logic [7:0]  t;
    logic        in_zone;
    logic [11:0] span;

    always_comb begin
        t       = {1'b0, track} + 8'd1;
        spt     = '0;
        start   = '0;
        in_zone = 1'b0;
        for (int unsigned i = 0; i < ZONES; i++) begin
            if (t >= ZONE_FIRST[drv_type][i[1:0]] && t <= ZONE_LAST[drv_type][i[1:0]]) begin
                in_zone = 1'b1;
                spt     = ZONE_SPT[drv_type][i[1:0]];
                start   = ZONE_START[drv_type][i[1:0]]
                        + ({4'd0, t - ZONE_FIRST[drv_type][i[1:0]]} * {7'd0, ZONE_SPT[drv_type][i[1:0]]});
            end
        end
        span  = start + {7'd0, spt};
        valid = in_zone && ({12'd0, span, 8'd0} <= img_size);
    end

endmodule

// File: rtl/ieeedrv_track_loader.sv
// Moves whole tracks between the host image and the track RAM, one 256-byte
// block per host handshake; dirty-track saves take priority over loads.
module ieeedrv_track_loader
    import ieeedrv_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        drv_type,
    input  logic        img_mounted,
    input  logic [31:0] img_size,
    input  logic        img_readonly,
    input  logic [6:0]  track,
    input  logic        save_track,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic        sd_buff_wr,
    output logic [12:0] buf_addr,
    output logic        buf_we,
    output logic        busy,
    output logic        track_ok
);

    state_t      state;
    logic [4:0]  sector;
    logic [6:0]  cur_track;
    logic [31:0] size_q;
    logic        save_pend;
    logic        load_pend;
    logic        remount;
    logic        save_prev;

    logic [4:0]  g_spt;
    logic [11:0] g_start;
    logic        g_valid;
    logic [4:0]  sector_next;
    logic        last_block;
    logic        retarget;

    ieeedrv_track_geom u_geom (
        .drv_type (drv_type),
        .track    (cur_track),
        .img_size (size_q),
        .spt      (g_spt),
        .start    (g_start),
        .valid    (g_valid)
    );

    assign sector_next = sector + 5'd1;
    assign last_block  = (sector_next == g_spt);
    assign retarget    = (track != cur_track) || remount;

    assign buf_addr = {sector, sd_buff_addr};
    assign buf_we   = sd_buff_wr & sd_ack & (state == S_LOAD_WAIT);
    assign busy     = (state != S_IDLE) || save_pend || load_pend;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            sd_lba    <= '0;
            sector    <= '0;
            save_pend <= 1'b0;
            load_pend <= 1'b0;
            remount   <= 1'b0;
            track_ok  <= 1'b0;
            cur_track <= '0;
            size_q    <= '0;
            save_prev <= save_track;
        end else begin
            save_prev <= save_track;
            case (state)
                S_IDLE: begin
                    if (save_pend) begin
                        sector <= '0;
                        state  <= S_SAVE_REQ;
                    end else if (load_pend) begin
                        cur_track <= track;
                        sector    <= '0;
                        track_ok  <= 1'b0;
                        remount   <= 1'b0;
                        state     <= S_LOAD_REQ;
                    end
                end
                S_SAVE_REQ: begin
                    if (!sd_wr) begin
                        if (!g_valid || !save_pend) begin
                            save_pend <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            sd_wr  <= 1'b1;
                            sd_lba <= {20'd0, g_start + {7'd0, sector}};
                        end
                    end else if (sd_ack) begin
                        sd_wr <= 1'b0;
                        state <= S_SAVE_WAIT;
                    end
                end
                S_SAVE_WAIT: begin
                    if (!sd_ack) begin
                        sector <= sector_next;
                        if (last_block) begin
                            save_pend <= 1'b0;
                            state     <= S_IDLE;
                        end else if (!save_pend) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_SAVE_REQ;
                        end
                    end
                end
                S_LOAD_REQ: begin
                    // A retarget before the request goes out just re-latches via IDLE.
                    if (!sd_rd) begin
                        if (retarget) begin
                            state <= S_IDLE;
                        end else if (!g_valid) begin
                            load_pend <= 1'b0;
                            track_ok  <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            sd_rd  <= 1'b1;
                            sd_lba <= {20'd0, g_start + {7'd0, sector}};
                        end
                    end else if (sd_ack) begin
                        sd_rd <= 1'b0;
                        state <= S_LOAD_WAIT;
                    end
                end
                S_LOAD_WAIT: begin
                    if (!sd_ack) begin
                        sector <= sector_next;
                        if (retarget) begin
                            state <= S_IDLE;
                        end else if (last_block) begin
                            load_pend <= 1'b0;
                            track_ok  <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_LOAD_REQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Request flags are applied last so a new event wins over a same-cycle clear.
            if ((save_track != save_prev) && !img_readonly)
                save_pend <= 1'b1;
            if (track != cur_track)
                load_pend <= 1'b1;
            if (img_mounted) begin
                size_q    <= img_size;
                save_pend <= 1'b0;
                track_ok  <= 1'b0;
                if (img_size != 32'd0) begin
                    load_pend <= 1'b1;
                    remount   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ieeedrv_track_loader.sv
// Scenario bench for the track loader: a host model records every block
// request, and each scenario compares them against its expected transfers.
module tb_ieeedrv_track_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        drv_type = 1'b0;
    logic        img_mounted = 1'b0;
    logic [31:0] img_size = '0;
    logic        img_readonly = 1'b0;
    logic [6:0]  track = '0;
    logic        save_track = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack = 1'b0;
    logic [7:0]  sd_buff_addr = '0;
    logic        sd_buff_wr = 1'b0;
    logic [12:0] buf_addr;
    logic        buf_we;
    logic        busy;
    logic        track_ok;

    int passed = 0;
    int total = 0;
    logic host_hold = 1'b0;
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];

    ieeedrv_track_loader dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .drv_type     (drv_type),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .track        (track),
        .save_track   (save_track),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_wr   (sd_buff_wr),
        .buf_addr     (buf_addr),
        .buf_we       (buf_we),
        .busy         (busy),
        .track_ok     (track_ok)
    );

    always #5 clk_sys = ~clk_sys;

    // Host: logs each request {wr, lba}, acks it briefly, then releases.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset && !sd_ack && (sd_rd || sd_wr)) begin
                obs_q.push_back({sd_wr, sd_lba});
                @(negedge clk_sys);
                sd_ack = 1'b1;
                @(negedge clk_sys);
                @(negedge clk_sys);
                while (host_hold) @(negedge clk_sys);
                sd_ack = 1'b0;
            end
        end
    end

    task automatic push_range(input logic wr, input int first, input int count);
        for (int i = 0; i < count; i++)
            exp_q.push_back({wr, 32'(first + i)});
    endtask

    task automatic mount(input logic drv, input logic [6:0] trk, input logic [31:0] size);
        @(negedge clk_sys);
        drv_type    = drv;
        track       = trk;
        img_size    = size;
        img_mounted = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
    endtask

    task automatic wait_idle(output logic timed_out);
        int n;
        repeat (3) @(negedge clk_sys);
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (2) @(negedge clk_sys);
        timed_out = busy;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        save_track = 1'b1;
        @(negedge clk_sys);
        total++; if (sd_rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", sd_rd); else passed++;
        total++; if (sd_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", sd_wr); else passed++;
        total++; if (sd_lba !== 32'd0) $display("FAIL reset_lba: got %0d want 0", sd_lba); else passed++;
        total++; if (track_ok !== 1'b0) $display("FAIL reset_track_ok: got %b want 0", track_ok); else passed++;
        reset = 1'b0;
        repeat (6) @(negedge clk_sys);
        total++; if (busy !== 1'b0) $display("FAIL reset_no_spurious_save: busy got %b want 0", busy); else passed++;
        total++; if (obs_q.size() != 0) $display("FAIL reset_no_xfer: got %0d transfers want 0", obs_q.size()); else passed++;
        obs_q.delete();
    endtask

    task automatic test_load_4040;
        logic to;
        logic [32:0] e, o;
        push_range(1'b0, 0, 21);
        mount(1'b1, 7'd0, 32'd174848);
        wait_idle(to);
        total++; if (to) $display("FAIL load0_timeout: busy got 1 want 0"); else passed++;
        total++; if (track_ok !== 1'b1) $display("FAIL load0_track_ok: got %b want 1", track_ok); else passed++;
        @(negedge clk_sys);
        track = 7'd16;
        push_range(1'b0, 336, 21);
        wait_idle(to);
        @(negedge clk_sys);
        track = 7'd17;
        push_range(1'b0, 357, 19);
        wait_idle(to);
        total++; if (to) $display("FAIL load17_timeout: busy got 1 want 0"); else passed++;
        total++; if (track_ok !== 1'b1) $display("FAIL load17_track_ok: got %b want 1", track_ok); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL load_xfer: got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL load_xfer: got %h want %h", o, e); else passed++;
            end
        end
        total++; if (obs_q.size() != 0) $display("FAIL load_extra: got %0d extra want 0", obs_q.size()); else passed++;
        obs_q.delete();
    endtask

    task automatic test_save_then_load;
        logic to;
        logic [32:0] e, o;
        push_range(1'b0, 1102, 29);
        mount(1'b0, 7'd38, 32'd533248);
        wait_idle(to);
        @(negedge clk_sys);
        save_track = ~save_track;
        track      = 7'd39;
        push_range(1'b1, 1102, 29);
        push_range(1'b0, 1131, 27);
        wait_idle(to);
        total++; if (to) $display("FAIL save_timeout: busy got 1 want 0"); else passed++;
        total++; if (track_ok !== 1'b1) $display("FAIL save_track_ok: got %b want 1", track_ok); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL save_xfer: got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL save_xfer: got %h want %h", o, e); else passed++;
            end
        end
        total++; if (obs_q.size() != 0) $display("FAIL save_extra: got %0d extra want 0", obs_q.size()); else passed++;
        obs_q.delete();
    endtask

    task automatic test_track_change_mid_load;
        logic to;
        int n;
        logic [32:0] e, o;
        push_range(1'b0, 105, 4);
        push_range(1'b0, 126, 21);
        mount(1'b1, 7'd5, 32'd174848);
        n = 0;
        while (!(obs_q.size() == 4 && sd_ack) && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        total++; if (n >= 2000) $display("FAIL midload_block3: not reached want ack of block 3"); else passed++;
        track = 7'd6;
        wait_idle(to);
        total++; if (to) $display("FAIL midload_timeout: busy got 1 want 0"); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL midload_xfer: got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL midload_xfer: got %h want %h", o, e); else passed++;
            end
        end
        total++; if (obs_q.size() != 0) $display("FAIL midload_extra: got %0d extra want 0", obs_q.size()); else passed++;
        obs_q.delete();
    endtask

    task automatic test_readonly_invalid;
        logic to;
        logic [32:0] e, o;
        @(negedge clk_sys);
        img_readonly = 1'b1;
        save_track = ~save_track;
        repeat (4) @(negedge clk_sys);
        save_track = ~save_track;
        wait_idle(to);
        img_readonly = 1'b0;
        total++; if (obs_q.size() != 0) $display("FAIL ro_no_write: got %0d transfers want 0", obs_q.size()); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL ro_busy: got %b want 0", busy); else passed++;
        @(negedge clk_sys);
        track = 7'd40;
        wait_idle(to);
        total++; if (obs_q.size() != 0) $display("FAIL inv_no_read: got %0d transfers want 0", obs_q.size()); else passed++;
        total++; if (track_ok !== 1'b0) $display("FAIL inv_track_ok: got %b want 0", track_ok); else passed++;
        mount(1'b1, 7'd0, 32'd5375);
        wait_idle(to);
        total++; if (obs_q.size() != 0) $display("FAIL short_img_no_read: got %0d transfers want 0", obs_q.size()); else passed++;
        total++; if (track_ok !== 1'b0) $display("FAIL short_img_track_ok: got %b want 0", track_ok); else passed++;
        push_range(1'b0, 0, 21);
        mount(1'b1, 7'd0, 32'd5376);
        wait_idle(to);
        total++; if (track_ok !== 1'b1) $display("FAIL exact_img_track_ok: got %b want 1", track_ok); else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL exact_img_xfer: got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL exact_img_xfer: got %h want %h", o, e); else passed++;
            end
        end
        total++; if (obs_q.size() != 0) $display("FAIL exact_img_extra: got %0d extra want 0", obs_q.size()); else passed++;
        obs_q.delete();
    endtask

    task automatic test_reset_in_load;
        int n;
        host_hold = 1'b1;
        mount(1'b1, 7'd0, 32'd174848);
        n = 0;
        while (!sd_ack && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        total++; if (!sd_ack) $display("FAIL rst_load_ack: got 0 want 1"); else passed++;
        @(negedge clk_sys);
        sd_buff_addr = 8'h5A;
        sd_buff_wr   = 1'b1;
        #1;
        total++; if (buf_we !== 1'b1) $display("FAIL buf_we: got %b want 1", buf_we); else passed++;
        total++; if (buf_addr !== 13'h005A) $display("FAIL buf_addr: got %h want 005a", buf_addr); else passed++;
        total++; if (obs_q.size() != 1 || obs_q[0] !== 33'd0) $display("FAIL rst_load_lba: got %0d reqs want one read of lba 0", obs_q.size()); else passed++;
        reset = 1'b1;
        @(negedge clk_sys);
        total++; if (sd_rd !== 1'b0) $display("FAIL rst_load_rd: got %b want 0", sd_rd); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_load_busy: got %b want 0", busy); else passed++;
        total++; if (track_ok !== 1'b0) $display("FAIL rst_load_track_ok: got %b want 0", track_ok); else passed++;
        sd_buff_wr = 1'b0;
        host_hold  = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        obs_q.delete();
        repeat (8) @(negedge clk_sys);
        total++; if (busy !== 1'b0 || obs_q.size() != 0) $display("FAIL post_reset_idle: busy %b reqs %0d want 0 0", busy, obs_q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_4040();
        test_save_then_load();
        test_track_change_mid_load();
        test_readonly_invalid();
        test_reset_in_load();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
